// File: rtl/tron_pkg.sv
// tron_pkg: shared definitions for the light-cycle game blocks.
//   - Game_State codes driven by the top-level game FSM.
//   - scorer_state_t: state encoding of round_scorer (also exported on its
//     debug port so checkers can bind to it).
//   - pidx_w(): width of a player index, never less than one bit.
package tron_pkg;

  localparam logic [2:0] GS_MENU = 3'd0;
  localparam logic [2:0] GS_PLAY = 3'd1;
  localparam logic [2:0] GS_OVER = 3'd4;

  typedef enum logic [1:0] {
    SC_IDLE       = 2'd0,
    SC_PLAY       = 2'd1,
    SC_HOLD       = 2'd2,
    SC_MATCH_OVER = 2'd3
  } scorer_state_t;

  function automatic int pidx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: turns the ~60 Hz frame strobe into a one-clk tick pulse.
//
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous active-high reset
//   frame_clk  in  frame strobe
//   tick       out one-cycle pulse, registered, per frame_clk rising edge
//
// Build option ROUND_SCORER_FRAME_SYNC_EN: when defined, frame_clk is treated
// as asynchronous and passes through a 2-flop synchroniser before the edge
// detector (tick arrives 3 cycles after the edge instead of 1).
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic frame_clk,
  output logic tick
);

  logic frame_s;
  logic prev_q, prev_d;
  logic tick_q, tick_d;

`ifdef ROUND_SCORER_FRAME_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
    end
  end

  assign frame_s = sync2_q;
`else
  assign frame_s = frame_clk;
`endif

  always_comb begin
    prev_d = frame_s;
    tick_d = frame_s & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/round_scorer.sv
// round_scorer: N-player round/match scorer for the light-cycle game.
// Each frame tick it removes crashed players from the alive mask, awards the
// round to the last survivor (or flags a draw), waits HOLD_FRAMES ticks,
// pulses reset_round to restart the arena, and latches the match winner once
// a score reaches WIN_SCORE.
//
// Ports:
//   Clk           in  system clock
//   Reset         in  asynchronous active-high reset
//   frame_clk     in  frame strobe (see frame_tick_gen)
//   Game_State    in  game-state code (tron_pkg GS_*)
//   score_clr     in  synchronous clear of scores, flags and state
//   player_color  in  per-player colour under the head, 0 = crash
//   score         out packed per-player scores
//   win           out sticky match-winner flags
//   round_winner  out index of the last round's survivor
//   round_draw    out last round ended with no survivor
//   round_active  out high while in PLAY
//   reset_round   out one-cycle arena restart pulse
//   dbg_state     out current scorer state
//
// Build option ROUND_SCORER_FRAME_SYNC_EN: adds a 2-flop synchroniser on
// frame_clk inside frame_tick_gen.
module round_scorer
  import tron_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int COLOR_W     = 8,
  parameter int SCORE_W     = 2,
  parameter int WIN_SCORE   = 3,
  parameter int HOLD_FRAMES = 60,
  localparam int PIDX_W     = pidx_w(NUM_PLAYERS)
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_clk,
  input  logic [2:0]                     Game_State,
  input  logic                           score_clr,
  input  logic [NUM_PLAYERS*COLOR_W-1:0] player_color,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [NUM_PLAYERS-1:0]         win,
  output logic [PIDX_W-1:0]              round_winner,
  output logic                           round_draw,
  output logic                           round_active,
  output logic                           reset_round,
  output scorer_state_t                  dbg_state
);

  localparam int HOLD_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam int CNT_W  = $clog2(NUM_PLAYERS + 1);

  if (WIN_SCORE < 1 || WIN_SCORE > (1 << SCORE_W) - 1) begin : g_bad_win_score
    $error("round_scorer: WIN_SCORE must be in 1..2^SCORE_W-1");
  end
  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8) begin : g_bad_num_players
    $error("round_scorer: NUM_PLAYERS must be in 2..8");
  end

  logic tick;

  frame_tick_gen u_tick (
    .clk       (Clk),
    .rst       (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  scorer_state_t                  state_q, state_d;
  logic [NUM_PLAYERS-1:0]         alive_q, alive_d;
  logic [NUM_PLAYERS*SCORE_W-1:0] score_q, score_d;
  logic [NUM_PLAYERS-1:0]         win_q, win_d;
  logic [PIDX_W-1:0]              round_winner_q, round_winner_d;
  logic                           round_draw_q, round_draw_d;
  logic                           round_active_q, round_active_d;
  logic                           reset_round_q, reset_round_d;
  logic [HOLD_W-1:0]              hold_cnt_q, hold_cnt_d;

  logic [NUM_PLAYERS-1:0] crashed;
  logic [NUM_PLAYERS-1:0] alive_next;
  logic [CNT_W-1:0]       alive_cnt;
  logic [PIDX_W-1:0]      surv_idx;
  logic [SCORE_W-1:0]     sc_cur;
  logic                   in_play;

  // Crash detection, popcount and survivor encoder. Masking with alive_q means
  // an already-eliminated player's crash colour has no effect.
  always_comb begin
    crashed   = '0;
    alive_cnt = '0;
    surv_idx  = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      crashed[i] = (player_color[i*COLOR_W +: COLOR_W] == '0);
    end
    alive_next = alive_q & ~crashed;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      alive_cnt = alive_cnt + CNT_W'(alive_next[i]);
      if (alive_next[i]) surv_idx = PIDX_W'(i);
    end
  end

  assign in_play = (Game_State == GS_PLAY);

  always_comb begin
    state_d        = state_q;
    alive_d        = alive_q;
    score_d        = score_q;
    win_d          = win_q;
    round_winner_d = round_winner_q;
    round_draw_d   = round_draw_q;
    hold_cnt_d     = hold_cnt_q;
    reset_round_d  = 1'b0;
    sc_cur         = '0;

    if (score_clr) begin
      state_d        = SC_IDLE;
      alive_d        = '1;
      score_d        = '0;
      win_d          = '0;
      round_winner_d = '0;
      round_draw_d   = 1'b0;
      hold_cnt_d     = '0;
    end else begin
      case (state_q)
        SC_IDLE: begin
          if (in_play) begin
            state_d = SC_PLAY;
            alive_d = '1;
          end
        end

        SC_PLAY: begin
          // Leaving GS_PLAY wins over a coincident tick: no scoring happens.
          if (!in_play) begin
            state_d = SC_IDLE;
            alive_d = '1;
          end else if (tick) begin
            alive_d = alive_next;
            if (alive_cnt == CNT_W'(1)) begin
              // alive_next is one-hot here, so it selects the survivor slot.
              for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (alive_next[i]) begin
                  sc_cur = score_q[i*SCORE_W +: SCORE_W];
                  if (sc_cur < SCORE_W'(WIN_SCORE)) sc_cur = sc_cur + 1'b1;
                  score_d[i*SCORE_W +: SCORE_W] = sc_cur;
                  if (sc_cur == SCORE_W'(WIN_SCORE)) win_d[i] = 1'b1;
                end
              end
              round_winner_d = surv_idx;
              round_draw_d   = 1'b0;
              state_d        = SC_HOLD;
              hold_cnt_d     = HOLD_W'(HOLD_FRAMES);
            end else if (alive_cnt == '0) begin
              round_draw_d = 1'b1;
              state_d      = SC_HOLD;
              hold_cnt_d   = HOLD_W'(HOLD_FRAMES);
            end
          end
        end

        SC_HOLD: begin
          if (!in_play) begin
            state_d = SC_IDLE;
            alive_d = '1;
          end else if (tick) begin
            if (hold_cnt_q == '0) begin
              if (|win_q) begin
                state_d = SC_MATCH_OVER;
              end else begin
                reset_round_d = 1'b1;
                alive_d       = '1;
                state_d       = SC_PLAY;
              end
            end else begin
              hold_cnt_d = hold_cnt_q - 1'b1;
            end
          end
        end

        SC_MATCH_OVER: begin
          // Only Reset or score_clr leave this state.
        end

        default: begin
          state_d = SC_IDLE;
          alive_d = '1;
        end
      endcase
    end

    round_active_d = (state_d == SC_PLAY);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= SC_IDLE;
      alive_q        <= '1;
      score_q        <= '0;
      win_q          <= '0;
      round_winner_q <= '0;
      round_draw_q   <= 1'b0;
      round_active_q <= 1'b0;
      reset_round_q  <= 1'b0;
      hold_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      alive_q        <= alive_d;
      score_q        <= score_d;
      win_q          <= win_d;
      round_winner_q <= round_winner_d;
      round_draw_q   <= round_draw_d;
      round_active_q <= round_active_d;
      reset_round_q  <= reset_round_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

  assign score        = score_q;
  assign win          = win_q;
  assign round_winner = round_winner_q;
  assign round_draw   = round_draw_q;
  assign round_active = round_active_q;
  assign reset_round  = reset_round_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_round_scorer.sv
// tb_round_scorer: directed bench for round_scorer. Two instances share the
// clock, reset and frame strobe: a 2-player scorer (red = P0, blue = P1) and
// a 4-player scorer, both with WIN_SCORE=3 and HOLD_FRAMES=2.
module tb_round_scorer;
  import tron_pkg::*;

  localparam logic [15:0] OK2 = 16'h2211;
  localparam logic [31:0] OK4 = 32'h44332211;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  logic frame_clk;
  always #5 Clk = ~Clk;

  // ---------------- DUT signals ----------------
  logic [2:0]    gs2, gs4;
  logic          clr2, clr4;
  logic [15:0]   col2;
  logic [31:0]   col4;
  logic [3:0]    score2;
  logic [7:0]    score4;
  logic [1:0]    win2;
  logic [3:0]    win4;
  logic [0:0]    rw2;
  logic [1:0]    rw4;
  logic          draw2, draw4, act2, act4, rr2, rr4;
  scorer_state_t st2, st4;

  round_scorer #(
    .NUM_PLAYERS(2), .COLOR_W(8), .SCORE_W(2), .WIN_SCORE(3), .HOLD_FRAMES(2)
  ) dut2 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(gs2),
    .score_clr(clr2), .player_color(col2), .score(score2), .win(win2),
    .round_winner(rw2), .round_draw(draw2), .round_active(act2),
    .reset_round(rr2), .dbg_state(st2)
  );

  round_scorer #(
    .NUM_PLAYERS(4), .COLOR_W(8), .SCORE_W(2), .WIN_SCORE(3), .HOLD_FRAMES(2)
  ) dut4 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(gs4),
    .score_clr(clr4), .player_color(col4), .score(score4), .win(win4),
    .round_winner(rw4), .round_draw(draw4), .round_active(act4),
    .reset_round(rr4), .dbg_state(st4)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance n clock edges; inputs change and outputs are sampled 1ns after.
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // One frame strobe; the scorer acts on it at the second edge, so outputs
  // are already updated when this returns.
  task automatic frame();
    frame_clk = 1'b1;
    step(1);
    frame_clk = 1'b0;
    step(1);
  endtask

  // Frame with a colour pattern applied only around the acting tick.
  task automatic frame2(input logic [15:0] c);
    col2 = c;
    frame();
    col2 = OK2;
  endtask

  task automatic frame4(input logic [31:0] c);
    col4 = c;
    frame();
    col4 = OK4;
  endtask

  // Three hold ticks on dut2 (counter 2 -> 1 -> 0 -> exit).
  task automatic hold2(input bit to_match);
    frame();
    check("hold_t1_rr", rr2, 0);
    frame();
    check("hold_t2_rr", rr2, 0);
    check("hold_t2_state", st2, SC_HOLD);
    frame();
    if (to_match) begin
      check("hold_end_no_rr", rr2, 0);
      check("hold_end_state", st2, SC_MATCH_OVER);
      check("hold_end_active", act2, 0);
    end else begin
      check("hold_end_rr", rr2, 1);
      check("hold_end_state", st2, SC_PLAY);
      check("hold_end_active", act2, 1);
      step(1);
      check("rr_one_cycle", rr2, 0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Reset = 1'b1; frame_clk = 1'b0;
    gs2 = GS_MENU; gs4 = GS_MENU; clr2 = 1'b0; clr4 = 1'b0;
    col2 = OK2; col4 = OK4;
    step(3);
    check("rst_score2", score2, 0);
    check("rst_win2", win2, 0);
    check("rst_rw2", rw2, 0);
    check("rst_draw2", draw2, 0);
    check("rst_act2", act2, 0);
    check("rst_rr2", rr2, 0);
    check("rst_state2", st2, SC_IDLE);
    check("rst_score4", score4, 0);
    Reset = 1'b0;
    step(1);

    // Round 1: red crashes, blue scores.
    gs2 = GS_PLAY;
    step(1);
    check("start_state", st2, SC_PLAY);
    check("start_active", act2, 1);
    frame2(16'h2200);
    check("r1_score", score2, 4'b0100);
    check("r1_winner", rw2, 1);
    check("r1_draw", draw2, 0);
    check("r1_state", st2, SC_HOLD);
    check("r1_active", act2, 0);
    hold2(0);

    // Round 2: simultaneous crash -> draw, still restarts.
    frame2(16'h0000);
    check("draw_score", score2, 4'b0100);
    check("draw_flag", draw2, 1);
    check("draw_winner_kept", rw2, 1);
    check("draw_state", st2, SC_HOLD);
    hold2(0);

    // Rounds 3 and 4: blue reaches 3 and wins the match.
    frame2(16'h2200);
    check("r3_score", score2, 4'b1000);
    check("r3_draw", draw2, 0);
    check("r3_win", win2, 0);
    hold2(0);
    frame2(16'h2200);
    check("r4_score", score2, 4'b1100);
    check("r4_win", win2, 2'b10);
    hold2(1);
    frame2(16'h2200);
    check("mo_score_held", score2, 4'b1100);
    check("mo_state", st2, SC_MATCH_OVER);
    gs2 = GS_OVER;
    step(1);
    check("mo_sticky_state", st2, SC_MATCH_OVER);
    check("mo_sticky_win", win2, 2'b10);

    // score_clr leaves MATCH_OVER.
    clr2 = 1'b1;
    step(1);
    clr2 = 1'b0;
    check("clr_score", score2, 0);
    check("clr_win", win2, 0);
    check("clr_rw", rw2, 0);
    check("clr_state", st2, SC_IDLE);

    // Game_State exit with a coincident double-crash tick: exit wins.
    gs2 = GS_PLAY;
    step(1);
    frame2(16'h2200);
    hold2(0);
    frame_clk = 1'b1;
    step(1);
    frame_clk = 1'b0; gs2 = GS_OVER; col2 = 16'h0000;
    step(1);
    col2 = OK2;
    check("exit_state", st2, SC_IDLE);
    check("exit_score", score2, 4'b0100);
    check("exit_draw", draw2, 0);
    check("exit_active", act2, 0);
    check("exit_rr", rr2, 0);
    step(1);
    check("exit_rr_late", rr2, 0);
    gs2 = GS_PLAY;
    step(1);
    check("return_state", st2, SC_PLAY);
    frame2(16'h0011);
    check("return_red_wins", score2, 4'b0101);
    check("return_winner", rw2, 0);

    // Reset during HOLD with counter at 1.
    frame();
    check("pre_rst_state", st2, SC_HOLD);
    Reset = 1'b1;
    #1;
    check("async_rst_score", score2, 0);
    check("async_rst_state", st2, SC_IDLE);
    check("async_rst_active", act2, 0);
    step(2);
    check("async_rst_rr", rr2, 0);
    Reset = 1'b0;
    step(1);

    // Same via score_clr: takes effect one edge later.
    frame2(16'h2200);
    frame();
    check("pre_clr_state", st2, SC_HOLD);
    clr2 = 1'b1;
    #1;
    check("clr_not_yet", score2, 4'b0100);
    step(1);
    clr2 = 1'b0;
    check("sclr_score", score2, 0);
    check("sclr_rw", rw2, 0);
    check("sclr_state", st2, SC_IDLE);
    step(1);
    check("sclr_no_rr", rr2, 0);
    check("sclr_replay", st2, SC_PLAY);

    // 4 players: P0 out, P0 again (ignored), P2 out, P1 out -> P3 scores.
    gs4 = GS_PLAY;
    step(1);
    frame4(32'h44332200);
    check("p4_a_state", st4, SC_PLAY);
    frame4(32'h44332200);
    check("p4_rep_state", st4, SC_PLAY);
    check("p4_rep_score", score4, 0);
    frame4(32'h44002211);
    check("p4_b_state", st4, SC_PLAY);
    frame4(32'h44330011);
    check("p4_score", score4, 8'h40);
    check("p4_winner", rw4, 3);
    check("p4_state", st4, SC_HOLD);
    check("p4_draw", draw4, 0);
    check("p4_win", win4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
